mux16_rr_arbiter: RTL and testbench

- Round-robin scheduler that shares a 16:1 single-bit select datapath among 16 requesters.
- Grants one requester at a time and drives the 4-bit select, so that requester's bit reaches a valid/ready output stream.
- Holds each grant for up to BURST_LEN accepted beats, then rotates priority.
- Sits between the requester bank and the downstream serial consumer; owns all sequencing of the mux select.

---
 rtl/mux16_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mux16_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux16_rr_arbiter
//
// Round-robin scheduler for a shared 16:1 single-bit select datapath. One
// requester at a time is granted. Its data bit is steered onto a valid/ready
// output stream for up to BURST_LEN accepted beats. Priority then rotates so
// that the requester just served has the lowest priority at the next
// arbitration.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   req        in  16   per-requester request
//   data_in    in  16   per-requester data bit
//   out_ready  in   1   downstream accepts a beat this cycle
//   out_valid  out  1   beat present on out_data
//   out_data   out  1   data_in[select] while transferring
//   out_src    out  4   index of the granted requester
//   select     out  4   mux select currently applied
//   grant      out 16   one-hot grant, zero when idle
//   busy       out  1   high while a grant is active
// -----------------------------------------------------------------------------
module mux16_rr_arbiter #(
   parameter int BURST_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic [15:0] data_in,
   input  logic        out_ready,
   output logic        out_valid,
   output logic        out_data,
   output logic [3:0]  out_src,
   output logic [3:0]  select,
   output logic [15:0] grant,
   output logic        busy
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [3:0]  select_q, select_d;
   logic [15:0] grant_q, grant_d;
   logic [4:0]  beat_cnt_q, beat_cnt_d;
   logic [3:0]  last_ptr_q, last_ptr_d;

   logic [3:0]  winner;
   logic        found;
   logic [3:0]  idx;
   logic        req_sel;
   logic        accept;
   logic        last_beat;

   // Cyclic search starting one past the last served requester. The 4-bit
   // wrap of idx implements the mod-16 rotation; i=16 lands on last_ptr
   // itself, so a lone requester can be granted again.
   always_comb begin
      found  = 1'b0;
      winner = 4'd0;
      idx    = 4'd0;
      for (int i = 1; i <= 16; i++) begin
         idx = last_ptr_q + 4'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign req_sel   = req[select_q];
   assign accept    = (state_q == XFER) && req_sel && out_ready;
   assign last_beat = (beat_cnt_q == 5'(BURST_LEN - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = XFER;
            end
         end
         XFER: begin
            // Withdrawal releases without taking a beat; otherwise release
            // only on the final accepted beat of the burst.
            if (!req_sel) begin
               state_d = IDLE;
            end else if (accept && last_beat) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant / select / counter next values
   always_comb begin
      select_d   = select_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      last_ptr_d = last_ptr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               select_d   = winner;
               grant_d    = 16'd1 << winner;
               beat_cnt_d = 5'd0;
            end
         end
         XFER: begin
            if (!req_sel) begin
               last_ptr_d = select_q;
               grant_d    = 16'd0;
            end else if (accept) begin
               if (last_beat) begin
                  last_ptr_d = select_q;
                  grant_d    = 16'd0;
                  beat_cnt_d = 5'd0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 5'd1;
               end
            end
         end
         default: begin
            grant_d = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         select_q   <= 4'd0;
         grant_q    <= 16'd0;
         beat_cnt_q <= 5'd0;
         last_ptr_q <= 4'd15;
      end else begin
         select_q   <= select_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         last_ptr_q <= last_ptr_d;
      end
   end

   // Output logic: the stream is combinational from the granted requester.
   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      out_data  = 1'b0;
      if (state_q == XFER) begin
         busy      = 1'b1;
         out_valid = req_sel;
         out_data  = data_in[select_q];
      end
   end

   assign select  = select_q;
   assign out_src = select_q;
   assign grant   = grant_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
module tb_mux16_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] req;
   logic [15:0] data_in;
   logic        out_ready;

   logic        out_valid, out_data, busy;
   logic [3:0]  out_src, select;
   logic [15:0] grant;

   logic        out_valid1, out_data1, busy1;
   logic [3:0]  out_src1, select1;
   logic [15:0] grant1;

   int n_tests;
   int n_fail;

   mux16_rr_arbiter #(.BURST_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .select    (select),
      .grant     (grant),
      .busy      (busy)
   );

   mux16_rr_arbiter #(.BURST_LEN(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_valid (out_valid1),
      .out_data  (out_data1),
      .out_src   (out_src1),
      .select    (select1),
      .grant     (grant1),
      .busy      (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_granted(input string tag, input int w);
      check({tag, " grant"}, 32'(grant), 32'(16'd1 << w));
      check({tag, " out_src"}, 32'(out_src), 32'(w));
      check({tag, " busy"}, 32'(busy), 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " grant"}, 32'(grant), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " out_valid"}, 32'(out_valid), 32'd0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      req       = 16'h0000;
      data_in   = 16'h0000;
      out_ready = 1'b0;

      // Reset values
      step();
      step();
      check("rst grant", 32'(grant), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_data", 32'(out_data), 32'd0);
      check("rst select", 32'(select), 32'd0);
      check("rst out_src", 32'(out_src), 32'd0);

      // Single requester 0, four-beat burst, bubble, re-grant
      rst       = 1'b0;
      req       = 16'h0001;
      data_in   = 16'h0001;
      out_ready = 1'b1;
      step();
      check_granted("t1 arb", 0);
      check("t1 out_valid", 32'(out_valid), 32'd1);
      check("t1 out_data hi", 32'(out_data), 32'd1);
      data_in = 16'hFFFE;
      #1;
      check("t1 out_data lo", 32'(out_data), 32'd0);
      data_in = 16'h0001;
      for (int b = 0; b < 3; b++) begin
         step();
         check_granted("t1 beat", 0);
      end
      step();
      check_idle("t1 bubble");
      step();
      check_granted("t1 regrant", 0);

      // Requesters 0 and 15 alternate
      req = 16'h8001;
      for (int b = 0; b < 3; b++) begin
         step();
         check_granted("t2 finish0", 0);
      end
      step();
      check_idle("t2 bubble0");
      for (int k = 0; k < 4; k++) begin
         int w;
         w = (k % 2 == 0) ? 15 : 0;
         step();
         check_granted("t2 arb", w);
         for (int b = 0; b < 3; b++) begin
            step();
            check_granted("t2 beat", w);
         end
         step();
         check_idle("t2 bubble");
      end

      // Stall on requester 5 with data toggling
      pulse_reset();
      req       = 16'h0020;
      data_in   = 16'h0000;
      out_ready = 1'b0;
      step();
      check_granted("t3 arb", 5);
      for (int c = 0; c < 10; c++) begin
         data_in = (c % 2 == 0) ? 16'h0020 : 16'hFFDF;
         #1;
         check_granted("t3 stall", 5);
         check("t3 out_valid", 32'(out_valid), 32'd1);
         check("t3 out_data", 32'(out_data), (c % 2 == 0) ? 32'd1 : 32'd0);
         step();
      end
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         step();
         check_granted("t3 resume", 5);
      end
      step();
      check_idle("t3 done");

      // Requester 3 withdraws after two beats; next search starts at 4
      pulse_reset();
      req = 16'h0008;
      step();
      check_granted("t4 arb", 3);
      step();
      step();
      check_granted("t4 two beats", 3);
      req = 16'h0006;
      #1;
      check("t4 withdraw valid", 32'(out_valid), 32'd0);
      step();
      check_idle("t4 release");
      step();
      check_granted("t4 next", 1);

      // Asynchronous reset mid-burst
      req = 16'hFFFF;
      rst = 1'b1;
      #2;
      check("t5 async out_valid", 32'(out_valid), 32'd0);
      check("t5 async grant", 32'(grant), 32'd0);
      check("t5 async busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();
      check_granted("t5 prio0", 0);

      // BURST_LEN=1 instance: one beat per grant, full rotation
      pulse_reset();
      req       = 16'hFFFF;
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         step();
         check("t6 grant", 32'(grant1), 32'(16'd1 << (k % 16)));
         check("t6 out_src", 32'(out_src1), 32'(k % 16));
         step();
         check("t6 bubble", 32'(grant1), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
